bin2bcd_seq: RTL and testbench



---
 rtl/calc_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 13 +
 rtl/bin2bcd_seq.sv | 107 ++++++++++
 tb/tb_bin2bcd_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, state type and helpers for the calculator display path
package calc_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int MAX_BCD_VAL = 9999;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Counter runs 0..bin_w-1, one step per converted bit.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - single BCD nibble add-3 correction for shift-and-add-3
module bcd_digit_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // A nibble of 5 or more would exceed 9 after the next shift, so pre-correct it.
  always_comb begin
    o_nib = i_nib;
    if (i_nib >= 4'd5) o_nib = i_nib + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter feeding the seven-segment display
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int          BIN_W    = 16,
  parameter logic [15:0] ERR_CODE = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  input  logic             dp_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             ovf,
  output logic             dp_out
);

  localparam int               SR_W  = 16 + BIN_W;
  localparam int               CNT_W = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);

  state_t            r_state;
  state_t            w_next;
  logic [SR_W-1:0]   r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_flag;
  logic              r_dp;
  logic              r_done;
  logic [15:0]       r_bcd;
  logic              r_ovf;
  logic              r_dp_out;
  logic [15:0]       w_adj;
  logic [SR_W-1:0]   w_shift;
  logic              w_last;

  // Add-3 correction on each BCD digit currently in the upper field.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_nib(r_sr[BIN_W + 4*g +: 4]),
      .o_nib(w_adj[4*g +: 4])
    );
  end

  // Carry out of the thousands digit falls off the top; only possible on overflow.
  assign w_shift = {w_adj, r_sr[BIN_W-1:0]} << 1;
  assign w_last  = (r_cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state: accept start only when idle, return after the final shift.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start)  w_next = CONV;
      CONV: if (w_last) w_next = IDLE;
    endcase
  end

  // Datapath: capture on start, shift per bit, publish results on the final shift only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr       <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
      r_dp       <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= 16'h0000;
      r_ovf      <= 1'b0;
      r_dp_out   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr       <= {16'h0000, bin};
            r_dp       <= dp_in;
            r_ovf_flag <= (bin > BIN_W'(MAX_BCD_VAL));
            r_cnt      <= '0;
          end
        end
        CONV: begin
          r_sr  <= w_shift;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_bcd    <= r_ovf_flag ? ERR_CODE : w_shift[SR_W-1 -: 16];
            r_ovf    <= r_ovf_flag;
            r_dp_out <= r_dp;
            r_done   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy   = (r_state == CONV);
  assign done   = r_done;
  assign bcd    = r_bcd;
  assign ovf    = r_ovf;
  assign dp_out = r_dp_out;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        dp_in = 1'b0;
  logic        busy, done, ovf, dp_out;
  logic [15:0] bcd;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] prev_bcd = 16'h0000;

  bin2bcd_seq #(.BIN_W(16), .ERR_CODE(16'hFFFF)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bin(bin), .dp_in(dp_in),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'hFFFF;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge, then scramble inputs (they may change freely after acceptance).
  task automatic start_conv(input logic [15:0] v, input logic d);
    @(negedge clk);
    start = 1'b1; bin = v; dp_in = d;
    @(negedge clk);
    start = 1'b0; bin = 16'($urandom); dp_in = 1'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Wait for done (bounded), checking that bcd stays frozen meanwhile.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (bcd !== prev_bcd) check("bcd_hold", 32'(bcd), 32'(prev_bcd));
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_check(input int v, input logic d, input int lat);
    check("latency", 32'(lat), 32'd16);
    check("done",    32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("bcd",     32'(bcd), 32'(ref_bcd(v)));
    check("ovf",     32'(ovf), 32'(v > 9999));
    check("dp_out",  32'(dp_out), 32'(d));
    prev_bcd = ref_bcd(v);
  endtask

  task automatic run_conv(input logic [15:0] v, input logic d);
    int lat;
    start_conv(v, d);
    wait_done(lat);
    finish_check(int'(v), d, lat);
    @(negedge clk);
    check("done_falls", 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [15:0] rv;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd), 32'd0);
    check("rst_ovf",  32'(ovf), 32'd0);
    check("rst_dp",   32'(dp_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed values and boundaries
    run_conv(16'd0, 1'b0);
    run_conv(16'd1234, 1'b1);
    run_conv(16'd9999, 1'b0);
    run_conv(16'd10000, 1'b1);
    run_conv(16'd65535, 1'b0);
    run_conv(16'd1, 1'b1);

    // Randomized values against the arithmetic model
    for (int i = 0; i < 10; i++) begin
      rv = 16'($urandom_range(0, 12000));
      run_conv(rv, 1'($urandom));
    end

    // Start while busy is ignored
    start_conv(16'd3141, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; bin = 16'd42;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    finish_check(3141, 1'b1, lat + 7);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("no_queued_conv", 32'(pulses), 32'd0);
    check("busy_idle_after_ignore", 32'(busy), 32'd0);

    // Back-to-back: start accepted in the done cycle
    start_conv(16'd789, 1'b1);
    wait_done(lat);
    finish_check(789, 1'b1, lat);
    start = 1'b1; bin = 16'd56; dp_in = 1'b0;
    @(negedge clk);
    start = 1'b0; bin = 16'($urandom);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    wait_done(lat);
    finish_check(56, 1'b0, lat);
    @(negedge clk);

    // Reset mid-conversion aborts with no done pulse
    start_conv(16'd777, 1'b1);
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd",  32'(bcd), 32'd0);
    check("abort_ovf",  32'(ovf), 32'd0);
    check("abort_dp",   32'(dp_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    prev_bcd = 16'h0000;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_conv(16'd777, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
